// File: rtl/id_imm_unit.sv
// Purpose : registered ID-stage immediate unit. Decodes the opcode into an
//           extension mode, forms the 32-bit operand (sign, zero or LUI),
//           the branch offset/target and the jump target, and registers the
//           results toward EX.
// Latency : 1 cycle (inputs sampled at edge N are visible after edge N).
// Backpr. : i_stall freezes the output register bit-stable. i_flush inserts a
//           bubble and wins over i_stall. There is no upstream ready signal.
// Ports   : i_clock/i_reset      clock, async active-high reset
//           i_instruction        ID-stage instruction word
//           i_pc_next            PC+4 of that instruction
//           i_valid              instruction is valid
//           i_stall/i_flush      hold / bubble control for the output register
//           o_valid              registered outputs are valid
//           o_imm                extended immediate
//           o_target             branch or jump target (0 for other modes)
//           o_mode               0 SIGN, 1 ZERO, 2 LUI, 3 BRANCH, 4 JUMP, 5 NONE
//           o_is_branch/o_is_jump  mode flags
module id_imm_unit #(
  parameter int NB_INST   = 32,
  parameter int NB_IMMED  = 16,
  parameter int NB_OPCODE = 6,
  parameter int NB_JADDR  = 26,
  parameter int NB_PC     = 32,   // must equal NB_JADDR + 6
  parameter int NB_MODE   = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_INST-1:0]   i_instruction,
  input  logic [NB_PC-1:0]     i_pc_next,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [NB_INST-1:0]   o_imm,
  output logic [NB_PC-1:0]     o_target,
  output logic [NB_MODE-1:0]   o_mode,
  output logic                 o_is_branch,
  output logic                 o_is_jump
);

  // ---------------------------------------------------------------------------
  // Mode encoding
  // ---------------------------------------------------------------------------
  localparam logic [NB_MODE-1:0] MODE_SIGN   = NB_MODE'(0);
  localparam logic [NB_MODE-1:0] MODE_ZERO   = NB_MODE'(1);
  localparam logic [NB_MODE-1:0] MODE_LUI    = NB_MODE'(2);
  localparam logic [NB_MODE-1:0] MODE_BRANCH = NB_MODE'(3);
  localparam logic [NB_MODE-1:0] MODE_JUMP   = NB_MODE'(4);
  localparam logic [NB_MODE-1:0] MODE_NONE   = NB_MODE'(5);

  // Opcodes of interest
  localparam logic [NB_OPCODE-1:0] OP_J     = NB_OPCODE'('h02);
  localparam logic [NB_OPCODE-1:0] OP_JAL   = NB_OPCODE'('h03);
  localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'('h04);
  localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'('h05);
  localparam logic [NB_OPCODE-1:0] OP_BLEZ  = NB_OPCODE'('h06);
  localparam logic [NB_OPCODE-1:0] OP_BGTZ  = NB_OPCODE'('h07);
  localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'('h08);
  localparam logic [NB_OPCODE-1:0] OP_ADDIU = NB_OPCODE'('h09);
  localparam logic [NB_OPCODE-1:0] OP_SLTI  = NB_OPCODE'('h0A);
  localparam logic [NB_OPCODE-1:0] OP_SLTIU = NB_OPCODE'('h0B);
  localparam logic [NB_OPCODE-1:0] OP_ANDI  = NB_OPCODE'('h0C);
  localparam logic [NB_OPCODE-1:0] OP_ORI   = NB_OPCODE'('h0D);
  localparam logic [NB_OPCODE-1:0] OP_XORI  = NB_OPCODE'('h0E);
  localparam logic [NB_OPCODE-1:0] OP_LUI   = NB_OPCODE'('h0F);
  localparam logic [NB_OPCODE-1:0] OP_MEM_LO = NB_OPCODE'('h20);
  localparam logic [NB_OPCODE-1:0] OP_MEM_HI = NB_OPCODE'('h2F);

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_IMMED-1:0]  imm_field;
  logic [NB_JADDR-1:0]  jidx;

  assign opcode    = i_instruction[NB_INST-1 -: NB_OPCODE];
  assign imm_field = i_instruction[NB_IMMED-1:0];
  assign jidx      = i_instruction[NB_JADDR-1:0];

  // ---------------------------------------------------------------------------
  // Opcode decode. Exact compares only; anything unlisted (including an
  // unknown opcode in simulation) falls through to NONE.
  // ---------------------------------------------------------------------------
  logic [NB_MODE-1:0] mode_c;

  always_comb begin
    mode_c = MODE_NONE;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI:               mode_c = MODE_ZERO;
      OP_LUI:                                 mode_c = MODE_LUI;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU:   mode_c = MODE_SIGN;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:       mode_c = MODE_BRANCH;
      OP_J, OP_JAL:                           mode_c = MODE_JUMP;
      default: begin
        // Loads and stores occupy a contiguous opcode block.
        if ((opcode >= OP_MEM_LO) && (opcode <= OP_MEM_HI)) begin
          mode_c = MODE_SIGN;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Candidate immediates and targets
  // ---------------------------------------------------------------------------
  logic [NB_INST-1:0] sext_c;
  logic [NB_INST-1:0] zext_c;
  logic [NB_INST-1:0] lui_c;
  logic [NB_INST-1:0] br_off_c;
  logic [NB_INST-1:0] j_off_c;
  logic [NB_PC-1:0]   br_tgt_c;
  logic [NB_PC-1:0]   j_tgt_c;

  assign sext_c   = {{(NB_INST-NB_IMMED){imm_field[NB_IMMED-1]}}, imm_field};
  assign zext_c   = {{(NB_INST-NB_IMMED){1'b0}}, imm_field};
  // Shifting inside NB_INST bits truncates the top of the field when the
  // word is narrower than twice the immediate.
  assign lui_c    = zext_c << NB_IMMED;
  // Word offset: the two bits shifted out of the top are discarded.
  assign br_off_c = sext_c << 2;
  assign j_off_c  = NB_INST'({jidx, 2'b00});
  // Wraps modulo 2^NB_PC; overflow is intentionally ignored.
  assign br_tgt_c = i_pc_next + NB_PC'(br_off_c);
  // Jump stays inside the current 256 MB region of PC+4.
  assign j_tgt_c  = {i_pc_next[NB_PC-1 -: 4], jidx, 2'b00};

  logic [NB_INST-1:0] imm_c;
  logic [NB_PC-1:0]   tgt_c;

  always_comb begin
    imm_c = '0;
    tgt_c = '0;
    case (mode_c)
      MODE_SIGN:   imm_c = sext_c;
      MODE_ZERO:   imm_c = zext_c;
      MODE_LUI:    imm_c = lui_c;
      MODE_BRANCH: begin
        imm_c = br_off_c;
        tgt_c = br_tgt_c;
      end
      MODE_JUMP: begin
        imm_c = j_off_c;
        tgt_c = j_tgt_c;
      end
      default: begin
        imm_c = '0;
        tgt_c = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ID/EX output register: flush > stall > load
  // ---------------------------------------------------------------------------
  logic               valid_q,  valid_d;
  logic [NB_INST-1:0] imm_q,    imm_d;
  logic [NB_PC-1:0]   tgt_q,    tgt_d;
  logic [NB_MODE-1:0] mode_q,   mode_d;
  logic               is_br_q,  is_br_d;
  logic               is_j_q,   is_j_d;

  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    is_br_d = is_br_q;
    is_j_d  = is_j_q;
    if (i_flush) begin
      valid_d = 1'b0;
      imm_d   = '0;
      tgt_d   = '0;
      mode_d  = '0;
      is_br_d = 1'b0;
      is_j_d  = 1'b0;
    end else if (!i_stall) begin
      // Data loads even when i_valid is low; downstream qualifies on o_valid.
      valid_d = i_valid;
      imm_d   = imm_c;
      tgt_d   = tgt_c;
      mode_d  = mode_c;
      is_br_d = (mode_c == MODE_BRANCH);
      is_j_d  = (mode_c == MODE_JUMP);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      tgt_q   <= '0;
      mode_q  <= '0;
      is_br_q <= 1'b0;
      is_j_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      is_br_q <= is_br_d;
      is_j_q  <= is_j_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_imm       = imm_q;
  assign o_target    = tgt_q;
  assign o_mode      = mode_q;
  assign o_is_branch = is_br_q;
  assign o_is_jump   = is_j_q;

endmodule

// File: tb/tb_id_imm_unit.sv
// Purpose : directed, table-driven bench for id_imm_unit plus hand-written
//           stall/flush and asynchronous-reset sequences.
// Ports   : none (top-level bench).
module tb_id_imm_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc_next;
  logic        vld;
  logic        stall;
  logic        flush;
  logic        o_valid;
  logic [31:0] o_imm;
  logic [31:0] o_target;
  logic [2:0]  o_mode;
  logic        o_is_branch;
  logic        o_is_jump;

  int n_vec = 0;
  int n_err = 0;

  id_imm_unit dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_instruction (instr),
    .i_pc_next     (pc_next),
    .i_valid       (vld),
    .i_stall       (stall),
    .i_flush       (flush),
    .o_valid       (o_valid),
    .o_imm         (o_imm),
    .o_target      (o_target),
    .o_mode        (o_mode),
    .o_is_branch   (o_is_branch),
    .o_is_jump     (o_is_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        vld;
    logic        e_vld;
    logic [31:0] e_imm;
    logic [31:0] e_tgt;
    logic [2:0]  e_mode;
    logic        e_br;
    logic        e_j;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] low);
    return {op, low};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compares every output; data fields are skipped when the expected result
  // is a bubble whose data content is don't-care.
  task automatic chk_all(input string nm, input logic e_vld, input logic [31:0] e_imm,
                         input logic [31:0] e_tgt, input logic [2:0] e_mode,
                         input logic e_br, input logic e_j, input logic mask);
    chk({nm, ".valid"}, 32'(o_valid), 32'(e_vld));
    if (!mask) begin
      chk({nm, ".imm"},    o_imm,             e_imm);
      chk({nm, ".target"}, o_target,          e_tgt);
      chk({nm, ".mode"},   32'(o_mode),       32'(e_mode));
      chk({nm, ".is_br"},  32'(o_is_branch),  32'(e_br));
      chk({nm, ".is_j"},   32'(o_is_jump),    32'(e_j));
    end
  endtask

  // Drive away from the edge, clock once, sample 1 ns after the edge.
  task automatic step(input logic [31:0] i, input logic [31:0] p, input logic v,
                      input logic s, input logic f);
    instr   = i;
    pc_next = p;
    vld     = v;
    stall   = s;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            name      instr                      pc            v  ev imm           tgt           md br j
    vecs.push_back('{"ori",    mk(6'h0D, 26'h0228001), 32'h0,        1, 1, 32'h00008001, 32'h0,        1, 0, 0});
    vecs.push_back('{"addi",   mk(6'h08, 26'h0228001), 32'h0,        1, 1, 32'hFFFF8001, 32'h0,        0, 0, 0});
    vecs.push_back('{"lui",    mk(6'h0F, 26'h0001234), 32'h0,        1, 1, 32'h12340000, 32'h0,        2, 0, 0});
    vecs.push_back('{"beq_n",  mk(6'h04, 26'h000FFFF), 32'h00000100, 1, 1, 32'hFFFFFFFC, 32'h000000FC, 3, 1, 0});
    vecs.push_back('{"beq_p",  mk(6'h04, 26'h0000010), 32'h00000100, 1, 1, 32'h00000040, 32'h00000140, 3, 1, 0});
    vecs.push_back('{"j",      mk(6'h02, 26'h0000010), 32'h40000004, 1, 1, 32'h00000040, 32'h40000040, 4, 0, 1});
    vecs.push_back('{"rtype",  mk(6'h00, 26'h0221820), 32'h00000200, 1, 1, 32'h0,        32'h0,        5, 0, 0});
    vecs.push_back('{"op3f",   mk(6'h3F, 26'h000ABCD), 32'h00000200, 1, 1, 32'h0,        32'h0,        5, 0, 0});
    vecs.push_back('{"lw",     mk(6'h23, 26'h000FFF0), 32'h0,        1, 1, 32'hFFFFFFF0, 32'h0,        0, 0, 0});
    vecs.push_back('{"xori",   mk(6'h0E, 26'h000FFFF), 32'h0,        1, 1, 32'h0000FFFF, 32'h0,        1, 0, 0});
    vecs.push_back('{"bgtz",   mk(6'h07, 26'h0008000), 32'h00001000, 1, 1, 32'hFFFE0000, 32'hFFFE1000, 3, 1, 0});
    vecs.push_back('{"jal",    mk(6'h03, 26'h3FFFFFF), 32'hF0000000, 1, 1, 32'h0FFFFFFC, 32'hFFFFFFFC, 4, 0, 1});
    vecs.push_back('{"sltiu",  mk(6'h0B, 26'h0007FFF), 32'h0,        1, 1, 32'h00007FFF, 32'h0,        0, 0, 0});
    vecs.push_back('{"sw",     mk(6'h2B, 26'h0008000), 32'h0,        1, 1, 32'hFFFF8000, 32'h0,        0, 0, 0});
    vecs.push_back('{"op30",   mk(6'h30, 26'h0001234), 32'h0,        1, 1, 32'h0,        32'h0,        5, 0, 0});
    vecs.push_back('{"op10",   mk(6'h10, 26'h0001234), 32'h0,        1, 1, 32'h0,        32'h0,        5, 0, 0});
    vecs.push_back('{"andi",   mk(6'h0C, 26'h000F00F), 32'h0,        1, 1, 32'h0000F00F, 32'h0,        1, 0, 0});
    vecs.push_back('{"inval",  mk(6'h08, 26'h0001111), 32'h0,        0, 0, 32'h0,        32'h0,        0, 0, 0});
    vecs.push_back('{"bne",    mk(6'h05, 26'h0000001), 32'hFFFFFFFC, 1, 1, 32'h00000004, 32'h00000000, 3, 1, 0});

    // Reset state
    rst = 1'b1; instr = '0; pc_next = '0; vld = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    rst = 1'b0;

    // Back-to-back table, one result per cycle
    foreach (vecs[k]) begin
      step(vecs[k].instr, vecs[k].pc, vecs[k].vld, 0, 0);
      chk_all(vecs[k].name, vecs[k].e_vld, vecs[k].e_imm, vecs[k].e_tgt,
              vecs[k].e_mode, vecs[k].e_br, vecs[k].e_j, !vecs[k].e_vld);
    end

    // Stall holds for 3 cycles while the inputs change
    step(mk(6'h08, 26'h0008001), 32'h0, 1, 0, 0);
    chk_all("stall_load", 1, 32'hFFFF8001, 32'h0, 3'd0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(mk(6'h04, 26'h000ABCD), 32'h00005000, (c != 1), 1, 0);
      chk_all($sformatf("stall_hold%0d", c), 1, 32'hFFFF8001, 32'h0, 3'd0, 0, 0, 0);
    end
    // Flush wins over stall
    step(mk(6'h0F, 26'h0001234), 32'h0, 1, 1, 1);
    chk_all("stall_flush", 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    // Flush alone with a valid instruction still gives a bubble
    step(mk(6'h0D, 26'h0001234), 32'h0, 1, 0, 1);
    chk_all("flush_only", 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    // Load resumes right after
    step(mk(6'h0F, 26'h000BEEF), 32'h0, 1, 0, 0);
    chk_all("post_flush", 1, 32'hBEEF0000, 32'h0, 3'd2, 0, 0, 0);

    // Asynchronous reset between edges while o_valid is high
    step(mk(6'h04, 26'h0000010), 32'h00000100, 1, 0, 0);
    chk_all("pre_areset", 1, 32'h00000040, 32'h00000140, 3'd3, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk_all("areset", 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    // Reset held across an edge, released, then a stalled edge must not load
    @(posedge clk);
    #1 rst = 1'b0;
    step(mk(6'h0D, 26'h0005555), 32'h0, 1, 1, 0);
    chk_all("rst_stall", 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    // First real load after reset: R-type
    step(mk(6'h00, 26'h0221820), 32'h0, 1, 0, 0);
    chk_all("rst_rtype", 1, 32'h0, 32'h0, 3'd5, 0, 0, 0);
    step(mk(6'h3F, 26'h3FFFFFF), 32'hFFFFFFFF, 1, 0, 0);
    chk_all("rst_op3f", 1, 32'h0, 32'h0, 3'd5, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
